counter_apb_arbiter: RTL and testbench

Two-requester APB master front-end that shares the counter's APB register slave (EN, RST, DIR, COUNT) between two independent controllers, e.g. a CPU bridge and a hardware sequencer. Requests are granted round-robin. Each granted request becomes one APB transfer with correct SETUP/ACCESS phasing and pready wait states. A watchdog aborts transfers whose pready never arrives, so one hung access cannot lock out the other requester.

---
 rtl/counter_apb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 34 +++
 rtl/counter_apb_arbiter.sv | 112 +++++++++++
 tb/tb_counter_apb_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_apb_pkg.sv
// Shared types and constants for the counter APB arbiter.
// FSM states, counter register map and read sentinel.
package counter_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam logic [31:0] OFS_EN      = 32'h0000_0000;
   localparam logic [31:0] OFS_RST     = 32'h0000_0004;
   localparam logic [31:0] OFS_DIR     = 32'h0000_0008;
   localparam logic [31:0] OFS_COUNT   = 32'h0000_000C;
   localparam logic [31:0] RD_SENTINEL = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from req and last_grant.
// Latency: 0 cycles to grant, last_grant updates on the advance edge.
// No backpressure: requests simply wait until advance is taken with their grant.
import counter_apb_pkg::*;

module rr_arb2 (
   input  logic       pclk,
   input  logic       preset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_grant;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Reset to 1 so requester 0 wins the first contended round.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset)
         last_grant <= 1'b1;
      else if (advance && (req != 2'b00))
         last_grant <= grant[1];
   end

endmodule

// File: rtl/counter_apb_arbiter.sv
// Shares one APB slave between two requesters, round-robin, one transfer per grant.
// Latency: grant edge -> SETUP -> ACCESS; done is combinational in the last ACCESS cycle.
// Backpressure: pready stretches ACCESS; the watchdog ends it with err after TIMEOUT_CYCLES.
import counter_apb_pkg::*;

module counter_apb_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   apb_state_t     state;
   logic [1:0]     grant;
   logic           gnt_idx;
   logic [TW-1:0]  tcnt;
   logic           timeout_hit;
   logic           xfer_end;
   logic [DATA_W-1:0] rsp_rdata;
   logic           rsp_err;

   rr_arb2 u_arb (
      .pclk    (pclk),
      .preset  (preset),
      .req     ({req1_valid, req0_valid}),
      .advance (state == IDLE),
      .grant   (grant)
   );

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && !pready && (tcnt == T_LAST);
   assign xfer_end    = (state == ACCESS) && (pready || timeout_hit);

   // A watchdog abort returns zero data and forces the error flag.
   assign rsp_rdata = pready ? prdata : '0;
   assign rsp_err   = pready ? pslverr : 1'b1;

   assign req0_done  = xfer_end && !gnt_idx;
   assign req1_done  = xfer_end &&  gnt_idx;
   assign req0_rdata = req0_done ? rsp_rdata : '0;
   assign req1_rdata = req1_done ? rsp_rdata : '0;
   assign req0_err   = req0_done && rsp_err;
   assign req1_err   = req1_done && rsp_err;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state   <= IDLE;
         psel    <= 1'b0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
         paddr   <= '0;
         pwdata  <= '0;
         gnt_idx <= 1'b0;
         tcnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant != 2'b00) begin
                  pwrite  <= grant[1] ? req1_write : req0_write;
                  paddr   <= grant[1] ? req1_addr  : req0_addr;
                  pwdata  <= grant[1] ? req1_wdata : req0_wdata;
                  gnt_idx <= grant[1];
                  tcnt    <= '0;
                  psel    <= 1'b1;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (xfer_end) begin
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  state   <= IDLE;
               end else if (TIMEOUT_CYCLES != 0) begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_apb_arbiter.sv
// Directed bench for counter_apb_arbiter with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.
module tb_counter_apb_arbiter;

   logic        pclk;
   logic        preset;
   logic        req0_valid, req0_write, req0_done, req0_err;
   logic [31:0] req0_addr, req0_wdata, req0_rdata;
   logic        req1_valid, req1_write, req1_done, req1_err;
   logic [31:0] req1_addr, req1_wdata, req1_rdata;
   logic [31:0] paddr, pwdata, prdata;
   logic        pwrite, psel, penable, pready, pslverr;

   int n_chk = 0;
   int n_bad = 0;

   counter_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .pclk(pclk), .preset(preset),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
      .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   task automatic do_reset();
      preset = 1'b1;
      cyc();
      cyc();
      preset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   int  ndone, last_t;
   logic exp_who, drop0, drop1;

   initial begin
      preset = 1'b1;
      req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
      req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
      prdata = 0; pready = 1; pslverr = 0;
      cyc();
      cyc();
      #1;
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_done0", req0_done, 0);

      // Write 1 to EN from requester 0, zero wait states
      cyc();
      preset = 1'b0;
      req0_valid = 1; req0_write = 1; req0_addr = 32'h0; req0_wdata = 32'h1;
      cyc(); #1;
      chk("wr_setup_psel", psel, 1);
      chk("wr_setup_penable", penable, 0);
      chk("wr_setup_paddr", paddr, 32'h0);
      chk("wr_setup_pwdata", pwdata, 32'h1);
      chk("wr_setup_pwrite", pwrite, 1);
      cyc(); #1;
      chk("wr_acc_penable", penable, 1);
      chk("wr_done0", req0_done, 1);
      chk("wr_err0", req0_err, 0);
      req0_valid = 0;
      cyc(); #1;
      chk("wr_idle_psel", psel, 0);

      // Read COUNT from requester 1
      req1_valid = 1; req1_write = 0; req1_addr = 32'hC; prdata = 32'h0000_002A;
      cyc(); #1;
      chk("rd_pwrite", pwrite, 0);
      chk("rd_paddr", paddr, 32'hC);
      cyc(); #1;
      chk("rd_done1", req1_done, 1);
      chk("rd_rdata1", req1_rdata, 32'h2A);
      chk("rd_err1", req1_err, 0);
      chk("rd_done0", req0_done, 0);
      chk("rd_rdata0", req0_rdata, 0);
      req1_valid = 0;

      // Both requesters contending from reset: alternate, 3-cycle spacing
      do_reset();
      req0_write = 1; req0_addr = 32'h4; req0_wdata = 32'hA0;
      req1_write = 1; req1_addr = 32'h8; req1_wdata = 32'hB1;
      exp_who = 0; ndone = 0; last_t = 0; drop0 = 0; drop1 = 0;
      for (int c = 0; c < 40 && ndone < 4; c++) begin
         cyc();
         req0_valid = !drop0; req1_valid = !drop1;
         drop0 = 0; drop1 = 0;
         #1;
         if (req0_done || req1_done) begin
            chk("rr_who", {31'b0, req1_done}, {31'b0, exp_who});
            chk("rr_wdata", pwdata, exp_who ? 32'hB1 : 32'hA0);
            if (ndone > 0) chk("rr_gap", c - last_t, 3);
            last_t = c;
            exp_who = !exp_who;
            ndone++;
            drop0 = req0_done; drop1 = req1_done;
         end
      end
      chk("rr_count", ndone, 4);
      req0_valid = 0; req1_valid = 0;

      // Three wait states then ready
      cyc();
      req0_valid = 1; req0_write = 1; req0_addr = 32'h8; req0_wdata = 32'h5A; pready = 0;
      cyc();
      for (int k = 1; k <= 4; k++) begin
         cyc();
         if (k == 4) pready = 1;
         #1;
         chk("ws_psel", psel, 1);
         chk("ws_penable", penable, 1);
         chk("ws_paddr", paddr, 32'h8);
         chk("ws_pwdata", pwdata, 32'h5A);
         chk("ws_done0", req0_done, (k == 4) ? 1 : 0);
      end
      chk("ws_err0", req0_err, 0);
      req0_valid = 0;
      cyc(); #1;
      chk("ws_idle_psel", psel, 0);

      // Hung read from requester 1, requester 0 waiting behind it
      pready = 0; prdata = 32'h1234;
      req1_valid = 1; req1_write = 0; req1_addr = 32'hC;
      req0_valid = 1; req0_write = 0; req0_addr = 32'h4;
      cyc(); #1;
      chk("to_grant_paddr", paddr, 32'hC);
      for (int k = 1; k <= 16; k++) begin
         cyc(); #1;
         if (k == 15) chk("to_early_done1", req1_done, 0);
         if (k == 16) begin
            chk("to_done1", req1_done, 1);
            chk("to_err1", req1_err, 1);
            chk("to_rdata1", req1_rdata, 0);
            chk("to_done0", req0_done, 0);
         end
      end
      req1_valid = 0;
      cyc(); #1;
      chk("to_idle_psel", psel, 0);
      cyc(); #1;
      chk("to_next_psel", psel, 1);
      chk("to_next_paddr", paddr, 32'h4);
      pready = 1; pslverr = 1;
      cyc(); #1;
      chk("slverr_done0", req0_done, 1);
      chk("slverr_err0", req0_err, 1);
      chk("slverr_rdata0", req0_rdata, 32'h1234);
      req0_valid = 0; pready = 0; pslverr = 0;

      // Reset in the middle of an ACCESS phase
      cyc();
      req0_valid = 1; req0_write = 1; req0_addr = 32'h0; req0_wdata = 32'h0;
      cyc();
      cyc(); #1;
      chk("mid_psel", psel, 1);
      chk("mid_penable", penable, 1);
      pready = 1;
      preset = 1;
      #1;
      chk("arst_psel", psel, 0);
      chk("arst_penable", penable, 0);
      chk("arst_done0", req0_done, 0);
      req0_write = 0; req0_addr = 32'h4;
      req1_write = 0; req1_addr = 32'hC; req1_valid = 1;
      cyc();
      preset = 0;
      cyc(); #1;
      chk("post_rst_paddr", paddr, 32'h4);
      cyc(); #1;
      chk("post_rst_done0", req0_done, 1);
      chk("post_rst_done1", req1_done, 0);
      req0_valid = 0; req1_valid = 0;
      cyc();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
